pdua_ctrl: RTL and testbench

Hardwired fetch/decode/execute control unit for the PDUA datapath. It drives every datapath control line: ALU, register bank, IR/MAR/MDR enables and memory direction. It sequences instructions from `out_IR` and the ALU flags, and adds a variable-latency memory handshake (`mem_req`/`mem_ack`) plus conditional branches. Register widths and bank size are parametrised so the same unit serves 8-bit and wider PDUA builds.

---
 rtl/pdua_ctrl_pkg.sv | 67 ++++++
 rtl/pdua_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_pdua_ctrl.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/pdua_ctrl_pkg.sv
// Shared constants for the PDUA control unit: FSM state codes, opcodes,
// ALU operation codes and register-bank index helpers.
package pdua_ctrl_pkg;

    localparam logic [3:0] S_CLR   = 4'd0;
    localparam logic [3:0] S_F_MAR = 4'd1;
    localparam logic [3:0] S_F_MEM = 4'd2;
    localparam logic [3:0] S_F_IR  = 4'd3;
    localparam logic [3:0] S_DEC   = 4'd4;
    localparam logic [3:0] S_E_MAR = 4'd5;
    localparam logic [3:0] S_E_RD  = 4'd6;
    localparam logic [3:0] S_E_WB  = 4'd7;
    localparam logic [3:0] S_E_WR  = 4'd8;
    localparam logic [3:0] S_E_WRQ = 4'd9;
    localparam logic [3:0] S_E_ALU = 4'd10;
    localparam logic [3:0] S_E_JMP = 4'd11;
    localparam logic [3:0] S_HALT  = 4'd12;

    localparam int unsigned OPC_NOP = 32'd0;
    localparam int unsigned OPC_LDA = 32'd1;
    localparam int unsigned OPC_STA = 32'd2;
    localparam int unsigned OPC_ADD = 32'd3;
    localparam int unsigned OPC_INC = 32'd4;
    localparam int unsigned OPC_JZ  = 32'd5;
    localparam int unsigned OPC_JN  = 32'd6;
    localparam int unsigned OPC_JMP = 32'd7;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_INC  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;

    // Width-independent control lines, bundled so reset gating is one assignment.
    typedef struct packed {
        logic       mem_req;
        logic       wr_rdn;
        logic       enaf;
        logic [2:0] selop;
        logic [1:0] shamt;
        logic       bank_wr_en;
        logic       sclr;
        logic       ir_en;
        logic       mar_en;
        logic       mdr_en;
        logic       mdr_alu_n;
        logic       halted;
    } ctrl_t;

    // The PC lives in the top bank entry; a word narrower than the bank index yields 0.
    function automatic int unsigned pc_idx(input int unsigned aw, input int unsigned mw);
        int unsigned idx;
        idx = (32'd1 << aw) - 32'd1;
        return (mw >= aw) ? idx : 32'd0;
    endfunction

    function automatic int unsigned acc_idx();
        return 32'd0;
    endfunction

    function automatic int unsigned dptr_idx();
        return 32'd1;
    endfunction

    function automatic int unsigned aux_idx();
        return 32'd2;
    endfunction

endpackage

// File: rtl/pdua_ctrl.sv
// Hardwired fetch/decode/execute controller for the PDUA datapath with a
// variable-latency memory handshake and conditional branches.
module pdua_ctrl
    import pdua_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned OP_WIDTH   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [OP_WIDTH-1:0]   out_IR,
    input  logic                  C,
    input  logic                  N,
    input  logic                  P,
    input  logic                  Z,
    input  logic                  mem_ack,
    output logic                  mem_req,
    output logic                  wr_rdn,
    output logic                  enaf,
    output logic [2:0]            selop,
    output logic [1:0]            shamt,
    output logic                  bank_wr_en,
    output logic [ADDR_WIDTH-1:0] BusB_addr,
    output logic [ADDR_WIDTH-1:0] BusC_addr,
    output logic                  sclr,
    output logic                  ir_en,
    output logic                  mar_en,
    output logic                  mdr_en,
    output logic                  mdr_alu_n,
    output logic                  halted
);

    localparam logic [ADDR_WIDTH-1:0] PC_A   = ADDR_WIDTH'(pc_idx(ADDR_WIDTH, MAX_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] ACC_A  = ADDR_WIDTH'(acc_idx());
    localparam logic [ADDR_WIDTH-1:0] DPTR_A = ADDR_WIDTH'(dptr_idx());
    localparam logic [ADDR_WIDTH-1:0] AUX_A  = ADDR_WIDTH'(aux_idx());

    localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(OPC_NOP);
    localparam logic [OP_WIDTH-1:0] OP_LDA  = OP_WIDTH'(OPC_LDA);
    localparam logic [OP_WIDTH-1:0] OP_STA  = OP_WIDTH'(OPC_STA);
    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(OPC_ADD);
    localparam logic [OP_WIDTH-1:0] OP_INC  = OP_WIDTH'(OPC_INC);
    localparam logic [OP_WIDTH-1:0] OP_JZ   = OP_WIDTH'(OPC_JZ);
    localparam logic [OP_WIDTH-1:0] OP_JN   = OP_WIDTH'(OPC_JN);
    localparam logic [OP_WIDTH-1:0] OP_JMP  = OP_WIDTH'(OPC_JMP);
    localparam logic [OP_WIDTH-1:0] OP_HALT = {OP_WIDTH{1'b1}};

    logic [3:0]            state_q;
    logic [3:0]            state_d;
    logic                  take_branch_s;
    ctrl_t                 ctrl_s;
    ctrl_t                 ctrl_gated_s;
    logic [ADDR_WIDTH-1:0] busb_s;
    logic [ADDR_WIDTH-1:0] busc_s;
    logic                  unused_flags_s;

    assign unused_flags_s = C ^ P;

    // State register; synchronous active-low reset parks the FSM in CLR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_CLR;
        end else begin
            state_q <= state_d;
        end
    end

    // Branch condition is evaluated on the flags present in the jump cycle itself.
    always_comb begin
        take_branch_s = 1'b0;
        if (out_IR == OP_JMP) begin
            take_branch_s = 1'b1;
        end else if (out_IR == OP_JZ) begin
            take_branch_s = Z;
        end else if (out_IR == OP_JN) begin
            take_branch_s = N;
        end else begin
            take_branch_s = 1'b0;
        end
    end

    // Next-state sequencing; memory states advance only on mem_ack.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CLR:   state_d = S_F_MAR;
            S_F_MAR: state_d = S_F_MEM;
            S_F_MEM: state_d = mem_ack ? S_F_IR : S_F_MEM;
            S_F_IR:  state_d = S_DEC;
            S_DEC: begin
                case (out_IR)
                    OP_HALT:                 state_d = S_HALT;
                    OP_NOP:                  state_d = S_F_MAR;
                    OP_LDA, OP_STA:          state_d = S_E_MAR;
                    OP_ADD, OP_INC:          state_d = S_E_ALU;
                    OP_JZ, OP_JN, OP_JMP:    state_d = S_E_JMP;
                    default:                 state_d = S_F_MAR;
                endcase
            end
            S_E_MAR: state_d = (out_IR == OP_LDA) ? S_E_RD : S_E_WR;
            S_E_RD:  state_d = mem_ack ? S_E_WB : S_E_RD;
            S_E_WB:  state_d = S_F_MAR;
            S_E_WR:  state_d = S_E_WRQ;
            S_E_WRQ: state_d = mem_ack ? S_F_MAR : S_E_WRQ;
            S_E_ALU: state_d = S_F_MAR;
            S_E_JMP: state_d = S_F_MAR;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_CLR;
        endcase
    end

    // Moore decode of the control lines; only mdr_en on a read sees mem_ack.
    always_comb begin
        ctrl_s = '0;
        busb_s = ACC_A;
        busc_s = ACC_A;
        case (state_q)
            S_CLR: ctrl_s.sclr = 1'b1;
            S_F_MAR: begin
                busb_s            = PC_A;
                busc_s            = PC_A;
                ctrl_s.selop      = ALU_INC;
                ctrl_s.mar_en     = 1'b1;
                ctrl_s.bank_wr_en = 1'b1;
            end
            S_F_MEM, S_E_RD: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.mdr_en  = mem_ack;
            end
            S_F_IR: ctrl_s.ir_en = 1'b1;
            S_DEC:  ctrl_s = '0;
            S_E_MAR: begin
                busb_s        = DPTR_A;
                ctrl_s.mar_en = 1'b1;
            end
            S_E_WB: begin
                busc_s            = ACC_A;
                ctrl_s.mdr_alu_n  = 1'b1;
                ctrl_s.bank_wr_en = 1'b1;
            end
            S_E_WR: begin
                busb_s        = ACC_A;
                ctrl_s.selop  = ALU_PASS;
                ctrl_s.mdr_en = 1'b1;
            end
            S_E_WRQ: begin
                ctrl_s.mem_req = 1'b1;
                ctrl_s.wr_rdn  = 1'b1;
            end
            S_E_ALU: begin
                if (out_IR == OP_ADD) begin
                    busb_s       = AUX_A;
                    ctrl_s.selop = ALU_ADD;
                end else begin
                    busb_s       = ACC_A;
                    ctrl_s.selop = ALU_INC;
                end
                busc_s            = ACC_A;
                ctrl_s.bank_wr_en = 1'b1;
                ctrl_s.enaf       = 1'b1;
            end
            S_E_JMP: begin
                if (take_branch_s) begin
                    busb_s            = DPTR_A;
                    busc_s            = PC_A;
                    ctrl_s.selop      = ALU_PASS;
                    ctrl_s.bank_wr_en = 1'b1;
                end else begin
                    busb_s = ACC_A;
                    busc_s = ACC_A;
                end
            end
            S_HALT:  ctrl_s.halted = 1'b1;
            default: ctrl_s = '0;
        endcase
    end

    // Everything reads zero while reset is held, including the CLR strobe.
    always_comb begin
        if (rst) begin
            ctrl_gated_s = ctrl_s;
            BusB_addr    = busb_s;
            BusC_addr    = busc_s;
        end else begin
            ctrl_gated_s = '0;
            BusB_addr    = '0;
            BusC_addr    = '0;
        end
    end

    assign mem_req    = ctrl_gated_s.mem_req;
    assign wr_rdn     = ctrl_gated_s.wr_rdn;
    assign enaf       = ctrl_gated_s.enaf;
    assign selop      = ctrl_gated_s.selop;
    assign shamt      = ctrl_gated_s.shamt;
    assign bank_wr_en = ctrl_gated_s.bank_wr_en;
    assign sclr       = ctrl_gated_s.sclr;
    assign ir_en      = ctrl_gated_s.ir_en;
    assign mar_en     = ctrl_gated_s.mar_en;
    assign mdr_en     = ctrl_gated_s.mdr_en;
    assign mdr_alu_n  = ctrl_gated_s.mdr_alu_n;
    assign halted     = ctrl_gated_s.halted;

endmodule

// File: tb/tb_pdua_ctrl.sv
// Directed bench for pdua_ctrl: per-cycle stimulus rows with hand-written
// expected output vectors, sampled on the falling edge.
module tb_pdua_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] out_IR;
    logic       C, N, P, Z;
    logic       mem_ack;
    logic       mem_req, wr_rdn, enaf;
    logic [2:0] selop;
    logic [1:0] shamt;
    logic       bank_wr_en;
    logic [2:0] BusB_addr, BusC_addr;
    logic       sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted;

    int tests = 0;
    int fails = 0;

    pdua_ctrl #(.MAX_WIDTH(8), .ADDR_WIDTH(3), .OP_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .out_IR(out_IR),
        .C(C), .N(N), .P(P), .Z(Z), .mem_ack(mem_ack),
        .mem_req(mem_req), .wr_rdn(wr_rdn), .enaf(enaf), .selop(selop),
        .shamt(shamt), .bank_wr_en(bank_wr_en),
        .BusB_addr(BusB_addr), .BusC_addr(BusC_addr),
        .sclr(sclr), .ir_en(ir_en), .mar_en(mar_en), .mdr_en(mdr_en),
        .mdr_alu_n(mdr_alu_n), .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {mem_req, wr_rdn, enaf, selop, shamt, bank_wr_en, BusB, BusC, sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted}
    logic [20:0] obs;
    assign obs = {mem_req, wr_rdn, enaf, selop, shamt, bank_wr_en, BusB_addr, BusC_addr,
                  sclr, ir_en, mar_en, mdr_en, mdr_alu_n, halted};

    localparam logic [20:0] E_ZERO  = 21'd0;
    localparam logic [20:0] E_CLR   = {3'b000, 3'b000, 2'b00, 1'b0, 3'd0, 3'd0, 6'b100000};
    localparam logic [20:0] E_FMAR  = {3'b000, 3'b001, 2'b00, 1'b1, 3'd7, 3'd7, 6'b001000};
    localparam logic [20:0] E_MEMW  = {3'b100, 3'b000, 2'b00, 1'b0, 3'd0, 3'd0, 6'b000000};
    localparam logic [20:0] E_MEMA  = {3'b100, 3'b000, 2'b00, 1'b0, 3'd0, 3'd0, 6'b000100};
    localparam logic [20:0] E_FIR   = {3'b000, 3'b000, 2'b00, 1'b0, 3'd0, 3'd0, 6'b010000};
    localparam logic [20:0] E_EMAR  = {3'b000, 3'b000, 2'b00, 1'b0, 3'd1, 3'd0, 6'b001000};
    localparam logic [20:0] E_EWB   = {3'b000, 3'b000, 2'b00, 1'b1, 3'd0, 3'd0, 6'b000010};
    localparam logic [20:0] E_EWR   = {3'b000, 3'b000, 2'b00, 1'b0, 3'd0, 3'd0, 6'b000100};
    localparam logic [20:0] E_EWRQ  = {3'b110, 3'b000, 2'b00, 1'b0, 3'd0, 3'd0, 6'b000000};
    localparam logic [20:0] E_ADD   = {3'b001, 3'b010, 2'b00, 1'b1, 3'd2, 3'd0, 6'b000000};
    localparam logic [20:0] E_INC   = {3'b001, 3'b001, 2'b00, 1'b1, 3'd0, 3'd0, 6'b000000};
    localparam logic [20:0] E_JT    = {3'b000, 3'b000, 2'b00, 1'b1, 3'd1, 3'd7, 6'b000000};
    localparam logic [20:0] E_HALT  = {3'b000, 3'b000, 2'b00, 1'b0, 3'd0, 3'd0, 6'b000001};

    typedef struct packed {
        logic        rs;
        logic [4:0]  ir;
        logic        ack;
        logic        z;
        logic        n;
        logic [20:0] exp;
    } row_t;

    function automatic row_t mk(input logic rs, input logic [4:0] ir, input logic ack,
                                input logic z, input logic n, input logic [20:0] e);
        row_t r;
        r.rs = rs; r.ir = ir; r.ack = ack; r.z = z; r.n = n; r.exp = e;
        return r;
    endfunction

    task automatic test_reset();
        row_t rows [5];
        rows = '{mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_ZERO),
                 mk(1'b0, 5'd0, 1'b1, 1'b0, 1'b0, E_ZERO),
                 mk(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, E_ZERO),
                 mk(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_CLR),
                 mk(1'b1, 5'd0, 1'b0, 1'b0, 1'b0, E_FMAR)};
        foreach (rows[i]) begin
            @(posedge clk); #1;
            rst = rows[i].rs; out_IR = rows[i].ir; mem_ack = rows[i].ack; Z = rows[i].z; N = rows[i].n;
            @(negedge clk);
            tests++;
            if (obs !== rows[i].exp) begin
                fails++;
                $display("FAIL reset row %0d: got %b expected %b", i, obs, rows[i].exp);
            end
        end
    endtask

    task automatic test_nop_stream();
        row_t rows [12];
        rows = '{mk(1'b1, 5'd0,  1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd0,  1'b1, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd0,  1'b1, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd0,  1'b1, 1'b0, 1'b0, E_FMAR),
                 mk(1'b1, 5'd9,  1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd9,  1'b1, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd9,  1'b1, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd9,  1'b1, 1'b0, 1'b0, E_FMAR),
                 mk(1'b1, 5'd30, 1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd30, 1'b1, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd30, 1'b1, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd30, 1'b1, 1'b0, 1'b0, E_FMAR)};
        foreach (rows[i]) begin
            @(posedge clk); #1;
            rst = rows[i].rs; out_IR = rows[i].ir; mem_ack = rows[i].ack; Z = rows[i].z; N = rows[i].n;
            @(negedge clk);
            tests++;
            if (obs !== rows[i].exp) begin
                fails++;
                $display("FAIL nop_stream row %0d: got %b expected %b", i, obs, rows[i].exp);
            end
        end
    endtask

    task automatic test_lda_wait();
        row_t rows [11];
        rows = '{mk(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, E_MEMW), mk(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, E_MEMW),
                 mk(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, E_MEMW), mk(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, E_MEMA),
                 mk(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, E_FIR),  mk(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, E_ZERO),
                 mk(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, E_EMAR), mk(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, E_MEMW),
                 mk(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd1, 1'b1, 1'b0, 1'b0, E_EWB),
                 mk(1'b1, 5'd1, 1'b0, 1'b0, 1'b0, E_FMAR)};
        foreach (rows[i]) begin
            @(posedge clk); #1;
            rst = rows[i].rs; out_IR = rows[i].ir; mem_ack = rows[i].ack; Z = rows[i].z; N = rows[i].n;
            @(negedge clk);
            tests++;
            if (obs !== rows[i].exp) begin
                fails++;
                $display("FAIL lda_wait row %0d: got %b expected %b", i, obs, rows[i].exp);
            end
        end
    endtask

    task automatic test_sta();
        row_t rows [9];
        rows = '{mk(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, E_EMAR),
                 mk(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, E_EWR),  mk(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, E_EWRQ),
                 mk(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, E_EWRQ), mk(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, E_EWRQ),
                 mk(1'b1, 5'd2, 1'b0, 1'b0, 1'b0, E_FMAR)};
        foreach (rows[i]) begin
            @(posedge clk); #1;
            rst = rows[i].rs; out_IR = rows[i].ir; mem_ack = rows[i].ack; Z = rows[i].z; N = rows[i].n;
            @(negedge clk);
            tests++;
            if (obs !== rows[i].exp) begin
                fails++;
                $display("FAIL sta row %0d: got %b expected %b", i, obs, rows[i].exp);
            end
        end
    endtask

    task automatic test_alu();
        row_t rows [10];
        rows = '{mk(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, E_ADD),
                 mk(1'b1, 5'd3, 1'b0, 1'b0, 1'b0, E_FMAR),
                 mk(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, E_INC),
                 mk(1'b1, 5'd4, 1'b0, 1'b0, 1'b0, E_FMAR)};
        foreach (rows[i]) begin
            @(posedge clk); #1;
            rst = rows[i].rs; out_IR = rows[i].ir; mem_ack = rows[i].ack; Z = rows[i].z; N = rows[i].n;
            @(negedge clk);
            tests++;
            if (obs !== rows[i].exp) begin
                fails++;
                $display("FAIL alu row %0d: got %b expected %b", i, obs, rows[i].exp);
            end
        end
    endtask

    // Flags are set in DEC to the opposite of their jump-cycle value.
    task automatic test_branch();
        row_t rows [25];
        rows = '{mk(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, E_MEMA), mk(1'b1, 5'd5, 1'b0, 1'b1, 1'b0, E_FIR),
                 mk(1'b1, 5'd5, 1'b0, 1'b1, 1'b0, E_ZERO), mk(1'b1, 5'd5, 1'b0, 1'b0, 1'b1, E_ZERO),
                 mk(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_FMAR),
                 mk(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd5, 1'b0, 1'b1, 1'b0, E_JT),
                 mk(1'b1, 5'd5, 1'b0, 1'b0, 1'b0, E_FMAR),
                 mk(1'b1, 5'd6, 1'b1, 1'b0, 1'b1, E_MEMA), mk(1'b1, 5'd6, 1'b0, 1'b0, 1'b1, E_FIR),
                 mk(1'b1, 5'd6, 1'b0, 1'b0, 1'b1, E_ZERO), mk(1'b1, 5'd6, 1'b0, 1'b1, 1'b0, E_ZERO),
                 mk(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, E_FMAR),
                 mk(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd6, 1'b0, 1'b0, 1'b1, E_JT),
                 mk(1'b1, 5'd6, 1'b0, 1'b0, 1'b0, E_FMAR),
                 mk(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_JT),
                 mk(1'b1, 5'd7, 1'b0, 1'b0, 1'b0, E_FMAR)};
        foreach (rows[i]) begin
            @(posedge clk); #1;
            rst = rows[i].rs; out_IR = rows[i].ir; mem_ack = rows[i].ack; Z = rows[i].z; N = rows[i].n;
            @(negedge clk);
            tests++;
            if (obs !== rows[i].exp) begin
                fails++;
                $display("FAIL branch row %0d: got %b expected %b", i, obs, rows[i].exp);
            end
        end
    endtask

    task automatic test_halt_reset();
        row_t rows [18];
        rows = '{mk(1'b1, 5'd31, 1'b1, 1'b0, 1'b0, E_MEMA), mk(1'b1, 5'd31, 1'b0, 1'b0, 1'b0, E_FIR),
                 mk(1'b1, 5'd31, 1'b0, 1'b0, 1'b0, E_ZERO), mk(1'b1, 5'd31, 1'b1, 1'b1, 1'b0, E_HALT),
                 mk(1'b1, 5'd31, 1'b1, 1'b0, 1'b1, E_HALT), mk(1'b1, 5'd0,  1'b1, 1'b0, 1'b0, E_HALT),
                 mk(1'b1, 5'd3,  1'b0, 1'b0, 1'b0, E_HALT),
                 mk(1'b0, 5'd0,  1'b0, 1'b0, 1'b0, E_ZERO), mk(1'b0, 5'd0,  1'b0, 1'b0, 1'b0, E_ZERO),
                 mk(1'b1, 5'd0,  1'b0, 1'b0, 1'b0, E_CLR),  mk(1'b1, 5'd0,  1'b0, 1'b0, 1'b0, E_FMAR),
                 mk(1'b1, 5'd0,  1'b0, 1'b0, 1'b0, E_MEMW), mk(1'b1, 5'd0,  1'b0, 1'b0, 1'b0, E_MEMW),
                 mk(1'b0, 5'd0,  1'b0, 1'b0, 1'b0, E_ZERO), mk(1'b0, 5'd0,  1'b1, 1'b0, 1'b0, E_ZERO),
                 mk(1'b1, 5'd0,  1'b1, 1'b0, 1'b0, E_CLR),  mk(1'b1, 5'd0,  1'b1, 1'b0, 1'b0, E_FMAR),
                 mk(1'b1, 5'd0,  1'b1, 1'b0, 1'b0, E_MEMA)};
        foreach (rows[i]) begin
            @(posedge clk); #1;
            rst = rows[i].rs; out_IR = rows[i].ir; mem_ack = rows[i].ack; Z = rows[i].z; N = rows[i].n;
            @(negedge clk);
            tests++;
            if (obs !== rows[i].exp) begin
                fails++;
                $display("FAIL halt_reset row %0d: got %b expected %b", i, obs, rows[i].exp);
            end
        end
    endtask

    initial begin
        rst = 1'b0; out_IR = 5'd0; mem_ack = 1'b0;
        C = 1'b0; N = 1'b0; P = 1'b0; Z = 1'b0;
        test_reset();
        test_nop_stream();
        test_lda_wait();
        test_sta();
        test_alu();
        test_branch();
        test_halt_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
